// File: rtl/muldiv_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : global_types (package)
// Description : Shared types and constants for the MULTU/DIVU HI/LO unit.
//               muldiv_op_t    - operation selected with start
//               muldiv_state_t - sequencer control states
//               MD_COUNT_W     - iteration counter width for the default WIDTH
// Revision    : 1.0 - initial release
// ============================================================================
package global_types;

    localparam int MD_WIDTH   = 32;
    localparam int MD_COUNT_W = $clog2(MD_WIDTH);

    typedef enum logic {
        MD_MULTU = 1'b0,
        MD_DIVU  = 1'b1
    } muldiv_op_t;

    typedef enum logic [1:0] {
        MD_IDLE   = 2'd0,
        MD_RUN    = 2'd1,
        MD_FINISH = 2'd2
    } muldiv_state_t;

endpackage : global_types
`default_nettype wire

// File: rtl/muldiv_sequencer_step.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_step
// Description : Purely combinational single iteration of the HI/LO datapath.
//               The accumulator is 2*WIDTH bits: {upper, lower}.
//               MULTU: lower holds the shifting multiplier; when its LSB is
//                      set the multiplicand is added into upper with carry,
//                      then the whole {carry, upper, lower} shifts right by 1.
//               DIVU : upper holds the partial remainder, lower the dividend
//                      being shifted out / quotient being shifted in
//                      (restoring division). The quotient bit lands in the
//                      LSB of the next accumulator.
// Ports       : i_op       - operation in flight
//               i_acc      - current accumulator
//               i_operand  - multiplicand (MULTU) or divisor (DIVU)
//               o_acc_next - accumulator after this iteration
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_step
    import global_types::*;
#(
    parameter int WIDTH = 32
) (
    input  muldiv_op_t           i_op,
    input  logic [2*WIDTH-1:0]   i_acc,
    input  logic [WIDTH-1:0]     i_operand,
    output logic [2*WIDTH-1:0]   o_acc_next
);

    logic [WIDTH-1:0]   w_upper;
    logic [WIDTH-1:0]   w_lower;

    // Multiply path
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_mul_next;

    // Divide path
    logic [WIDTH:0]     w_partial;
    logic [WIDTH+1:0]   w_diff;
    logic               w_qbit;
    logic [WIDTH-1:0]   w_rem;
    logic [2*WIDTH-1:0] w_div_next;
    logic               w_unused_diff;

    assign w_upper = i_acc[2*WIDTH-1:WIDTH];
    assign w_lower = i_acc[WIDTH-1:0];

    // Shift-add: the WIDTH+1 bit sum keeps the carry so nothing is lost
    // when it is shifted back down into the upper half.
    assign w_sum      = {1'b0, w_upper} + (w_lower[0] ? {1'b0, i_operand} : {(WIDTH+1){1'b0}});
    assign w_mul_next = {w_sum, w_lower[WIDTH-1:1]};

    // Restoring division: trial-subtract the divisor from {rem, next MSB}.
    // One extra guard bit makes the sign of the difference explicit.
    assign w_partial = {w_upper, w_lower[WIDTH-1]};
    assign w_diff    = {1'b0, w_partial} - {2'b00, i_operand};
    assign w_qbit    = ~w_diff[WIDTH+1];
    // A kept difference is always below the divisor, so it fits WIDTH bits;
    // a restored partial is below the divisor as well, so its top bit is 0.
    assign w_rem      = w_qbit ? w_diff[WIDTH-1:0] : w_partial[WIDTH-1:0];
    assign w_div_next = {w_rem, w_lower[WIDTH-2:0], w_qbit};

    assign w_unused_diff = w_diff[WIDTH];

    assign o_acc_next = (i_op == MD_DIVU) ? w_div_next : w_mul_next;

endmodule : muldiv_step
`default_nettype wire

// File: rtl/muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_sequencer
// Description : Iterative HI/LO unit executing MULTU and DIVU beside the ALU.
//               Owns the HI/LO registers, sequences one datapath iteration
//               per cycle and freezes the pipeline when a new mul/div or a
//               HI/LO read arrives while an operation is in flight.
//               Optional feature macro: MULDIV_EARLY_TERM_EN - MULTU leaves
//               RUN once the remaining multiplier bits are all zero.
// Ports       : clock    - system clock, rising edge
//               reset_n  - asynchronous active-low reset
//               start    - request new operation, held until accepted
//               op       - 0 = MULTU, 1 = DIVU, sampled with start
//               a, b     - rs / rt operands
//               read_req - MFHI/MFLO in decode
//               busy     - operation in RUN
//               stall    - pipeline freeze request
//               done     - one-cycle pulse, HI/LO hold the new result
//               hi, lo   - HI/LO registers
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_sequencer
    import global_types::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             read_req,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH);

    muldiv_state_t      r_state;
    muldiv_state_t      w_state_next;
    muldiv_op_t         r_op;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_operand;
    logic [CNT_W-1:0]   r_count;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic [2*WIDTH-1:0] w_acc_next;
    logic [2*WIDTH-1:0] w_result;
    logic               w_accept;
    logic               w_last;
    logic               w_busy;

    // ------------------------------------------------------------------
    // Single-iteration datapath
    // ------------------------------------------------------------------
    muldiv_step #(
        .WIDTH      (WIDTH)
    ) u_step (
        .i_op       (r_op),
        .i_acc      (r_acc),
        .i_operand  (r_operand),
        .o_acc_next (w_acc_next)
    );

    // ------------------------------------------------------------------
    // Termination and result alignment
    // ------------------------------------------------------------------
`ifdef MULDIV_EARLY_TERM_EN
    logic [WIDTH-1:0] r_mplier;
    logic [CNT_W:0]   w_cnt_inc;
    logic [CNT_W-1:0] w_shift;

    assign w_cnt_inc = {1'b0, r_count} + {{CNT_W{1'b0}}, 1'b1};
    // After count+1 iterations only b >> (count+1) remains to be consumed.
    assign w_last    = (r_count == CNT_W'(WIDTH-1)) ||
                       ((r_op == MD_MULTU) && ((r_mplier >> w_cnt_inc) == '0));
    // A MULTU stopped after n iterations sits WIDTH-n places too high.
    assign w_shift   = CNT_W'(WIDTH-1) - r_count;
    assign w_result  = (r_op == MD_MULTU) ? (w_acc_next >> w_shift) : w_acc_next;
`else
    assign w_last    = (r_count == CNT_W'(WIDTH-1));
    assign w_result  = w_acc_next;
`endif

    // ------------------------------------------------------------------
    // Control FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= MD_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Control FSM: next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_busy       = 1'b0;
        done         = 1'b0;
        case (r_state)
            MD_IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = MD_RUN;
                end
            end
            MD_RUN: begin
                w_busy = 1'b1;
                if (w_last) begin
                    w_state_next = MD_FINISH;
                end
            end
            MD_FINISH: begin
                done = 1'b1;
                // Back-to-back: a waiting requester is taken here directly.
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = MD_RUN;
                end else begin
                    w_state_next = MD_IDLE;
                end
            end
            default: begin
                w_state_next = MD_IDLE;
            end
        endcase
        busy  = w_busy;
        stall = w_busy & (start | read_req);
    end

    // ------------------------------------------------------------------
    // Datapath registers and HI/LO
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_op      <= MD_MULTU;
            r_acc     <= '0;
            r_operand <= '0;
            r_count   <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
`ifdef MULDIV_EARLY_TERM_EN
            r_mplier  <= '0;
`endif
        end else if (w_accept) begin
            // MULTU: lower = multiplier, operand = multiplicand.
            // DIVU : lower = dividend,   operand = divisor.
            r_op      <= muldiv_op_t'(op);
            r_operand <= op ? b : a;
            r_acc     <= {{WIDTH{1'b0}}, (op ? a : b)};
            r_count   <= '0;
`ifdef MULDIV_EARLY_TERM_EN
            r_mplier  <= b;
`endif
        end else if (r_state == MD_RUN) begin
            r_acc   <= w_acc_next;
            r_count <= r_count + 1'b1;
            // HI/LO change only here, so no partial result is ever visible.
            if (w_last) begin
                r_hi <= w_result[2*WIDTH-1:WIDTH];
                r_lo <= w_result[WIDTH-1:0];
            end
        end
    end

    assign hi = r_hi;
    assign lo = r_lo;

endmodule : muldiv_sequencer
`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_sequencer
// Description : Self-checking bench for muldiv_sequencer. A table of directed
//               MULTU/DIVU vectors with hand-computed HI/LO results, followed
//               by hand-written sequences for read stall, back-to-back start
//               and reset during RUN. Honours MULDIV_EARLY_TERM_EN for the
//               expected MULTU latency.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_sequencer;

    localparam int W = 32;

    logic         clock;
    logic         reset_n;
    logic         start;
    logic         op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         read_req;
    logic         busy;
    logic         stall;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int n_checks = 0;
    int n_fail   = 0;

    muldiv_sequencer #(
        .WIDTH    (W)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .read_req (read_req),
        .busy     (busy),
        .stall    (stall),
        .done     (done),
        .hi       (hi),
        .lo       (lo)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic         op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_hi;
        logic [W-1:0] exp_lo;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Expected RUN length: WIDTH, or highest set bit of b + 1 for an
    // early-terminating MULTU.
    function automatic int exp_lat(input logic o, input logic [W-1:0] y);
        int lat;
        lat = W;
`ifdef MULDIV_EARLY_TERM_EN
        if (o == 1'b0) begin
            lat = 1;
            for (int i = 0; i < W; i++) begin
                if (y[i]) lat = i + 1;
            end
        end
`endif
        return lat;
    endfunction

    // Issue one operation, then wait for done. Returns the number of cycles
    // from the sampling edge to done and how many of them had busy high.
    task automatic run_op(input logic o, input logic [W-1:0] x, input logic [W-1:0] y,
                          output int lat, output int busyc);
        @(negedge clock);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(posedge clock);
        #1;
        start = 1'b0;
        // Operand changes during RUN must not matter.
        a     = ~x;
        b     = ~y;
        op    = ~o;
        lat   = 0;
        busyc = 0;
        while (!done && lat < 200) begin
            if (busy) busyc++;
            @(posedge clock);
            #1;
            lat++;
        end
    endtask

    initial begin
        int lat;
        int busyc;
        int guard;
        int gap;
        int done_seen;
        logic [W-1:0] pr_hi;
        logic [W-1:0] pr_lo;

        vecs[0] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[1] = '{1'b1, 32'd100,       32'd7,         32'd2,         32'd14};
        vecs[2] = '{1'b1, 32'h0000_1234, 32'h0,         32'h0000_1234, 32'hFFFF_FFFF};
        vecs[3] = '{1'b0, 32'd3,         32'd5,         32'd0,         32'd15};
        vecs[4] = '{1'b0, 32'h1234_5678, 32'h0,         32'h0,         32'h0};
        vecs[5] = '{1'b1, 32'hFFFF_FFFF, 32'd1,         32'h0,         32'hFFFF_FFFF};
        vecs[6] = '{1'b0, 32'h8000_0000, 32'd2,         32'h1,         32'h0};
        vecs[7] = '{1'b1, 32'd7,         32'd100,       32'd7,         32'd0};
        vecs[8] = '{1'b0, 32'h0000_FFFF, 32'h0001_0001, 32'h0,         32'hFFFF_FFFF};

        reset_n  = 1'b0;
        start    = 1'b0;
        op       = 1'b0;
        a        = '0;
        b        = '0;
        read_req = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("reset_busy",  {63'd0, busy},  64'd0);
        check("reset_stall", {63'd0, stall}, 64'd0);
        check("reset_done",  {63'd0, done},  64'd0);
        check("reset_hi",    {32'd0, hi},    64'd0);
        check("reset_lo",    {32'd0, lo},    64'd0);
        @(negedge clock);
        reset_n = 1'b1;

        // ---------------- table-driven vectors ----------------
        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, busyc);
            check($sformatf("v%0d_latency", i), 64'(lat),   64'(exp_lat(vecs[i].op, vecs[i].b)));
            check($sformatf("v%0d_busycyc", i), 64'(busyc), 64'(exp_lat(vecs[i].op, vecs[i].b)));
            check($sformatf("v%0d_hi", i), {32'd0, hi}, {32'd0, vecs[i].exp_hi});
            check($sformatf("v%0d_lo", i), {32'd0, lo}, {32'd0, vecs[i].exp_lo});
            check($sformatf("v%0d_busy_in_finish", i), {63'd0, busy}, 64'd0);
            @(posedge clock);
            #1;
            check($sformatf("v%0d_done_one_cycle", i), {63'd0, done}, 64'd0);
        end
        pr_hi = vecs[8].exp_hi;
        pr_lo = vecs[8].exp_lo;

        // ---------------- read_req stall ----------------
        // 0x00010000 * 0x80000003 = 0x0000_8000_0003_0000 (32 RUN cycles either build)
        @(negedge clock);
        start = 1'b1;
        op    = 1'b0;
        a     = 32'h0001_0000;
        b     = 32'h8000_0003;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        read_req = 1'b1;
        #1;
        guard = 0;
        while (!done && guard < 100) begin
            check("rd_stall", {63'd0, stall}, 64'd1);
            check("rd_hi_held", {32'd0, hi}, {32'd0, pr_hi});
            check("rd_lo_held", {32'd0, lo}, {32'd0, pr_lo});
            @(posedge clock);
            #1;
            guard++;
        end
        check("rd_done", {63'd0, done}, 64'd1);
        check("rd_stall_finish", {63'd0, stall}, 64'd0);
        check("rd_hi", {32'd0, hi}, 64'h0000_8000);
        check("rd_lo", {32'd0, lo}, 64'h0003_0000);
        read_req = 1'b0;
        @(posedge clock);
        #1;

        // ---------------- back-to-back start ----------------
        // First DIVU FFFFFFFF / 0x10, second DIVU 1000 / 33 held during RUN.
        @(negedge clock);
        start = 1'b1;
        op    = 1'b1;
        a     = 32'hFFFF_FFFF;
        b     = 32'h0000_0010;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        start = 1'b1;
        op    = 1'b1;
        a     = 32'd1000;
        b     = 32'd33;
        #1;
        check("b2b_stall", {63'd0, stall}, 64'd1);
        check("b2b_busy",  {63'd0, busy},  64'd1);
        guard = 0;
        while (!done && guard < 100) begin
            @(posedge clock);
            #1;
            guard++;
        end
        check("b2b_first_done", {63'd0, done}, 64'd1);
        check("b2b_first_stall_finish", {63'd0, stall}, 64'd0);
        check("b2b_first_hi", {32'd0, hi}, 64'h0000_000F);
        check("b2b_first_lo", {32'd0, lo}, 64'h0FFF_FFFF);
        @(posedge clock);
        #1;
        start = 1'b0;
        check("b2b_accepted_busy", {63'd0, busy}, 64'd1);
        gap = 1;
        while (!done && gap < 100) begin
            @(posedge clock);
            #1;
            gap++;
        end
        check("b2b_gap", 64'(gap), 64'd33);
        check("b2b_second_hi", {32'd0, hi}, 64'd10);
        check("b2b_second_lo", {32'd0, lo}, 64'd30);
        @(posedge clock);
        #1;

        // ---------------- reset during RUN ----------------
        @(negedge clock);
        start = 1'b1;
        op    = 1'b0;
        a     = 32'd5;
        b     = 32'hFFFF_FFFF;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clock);
        #2;
        check("rst_pre_busy", {63'd0, busy}, 64'd1);
        reset_n = 1'b0;
        #1;
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_hi",   {32'd0, hi},   64'd0);
        check("rst_lo",   {32'd0, lo},   64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        done_seen = 0;
        repeat (40) begin
            @(posedge clock);
            #1;
            if (done || busy) done_seen++;
        end
        check("rst_no_done", 64'(done_seen), 64'd0);

        // ---------------- recovery after reset ----------------
        run_op(1'b0, 32'd6, 32'd7, lat, busyc);
        check("post_rst_latency", 64'(lat), 64'(exp_lat(1'b0, 32'd7)));
        check("post_rst_hi", {32'd0, hi}, 64'd0);
        check("post_rst_lo", {32'd0, lo}, 64'd42);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_muldiv_sequencer
`default_nettype wire
